// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes (a..g on bits 6..0),
// the blank BCD code, the capture FSM encoding and the decoder payload type.
// The display encoder imports the same code constants so both ends agree.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;

    // Active-low segment patterns, a..g on bits 6..0 (0 = lit)
    localparam logic [SEG_W-1:0] SEG_0     = 7'h01;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h4C;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h20;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h0F;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h04;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

    // Capture FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    // Decoded view of one segment pattern
    typedef struct packed {
        logic [BCD_W-1:0] bcd;
        logic             legal;
        logic             blank;
    } seg7_dec_t;

    // Forward mapping used by the encoder side; anything above 9 blanks the digit.
    function automatic logic [SEG_W-1:0] seg7_encode(input logic [BCD_W-1:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the segment encoder: active-low pattern -> BCD.
// Blank and illegal patterns both return BCD_BLANK; the flags tell them apart.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] bcd,
    output logic       legal,
    output logic       blank
);

    // Look the pattern up against the shared code table
    always_comb begin
        bcd   = BCD_BLANK;
        legal = 1'b1;
        blank = 1'b0;
        case (seg_n)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Readback receiver for a multiplexed common-anode 7-segment bus.
// Registers the pins, waits for STABLE_CYCLES identical samples with exactly
// one digit enable low, then decodes the stable pattern into that digit's slot.
// Optional feature: define SEG7_CAP_DP_EN to add the decimal point (dp_n/dp_out).
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
`ifdef SEG7_CAP_DP_EN
    input  logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    pattern_err
);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0] s_an;
    logic [NUM_DIGITS-1:0] p_an;
    logic [6:0]            s_seg;
    logic [6:0]            p_seg;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            state;
    logic [1:0]            state_nxt;

    logic                  changed_c;
    logic                  an_onehot_c;
    logic                  capture_c;
    logic [NUM_DIGITS-1:0] an_act_c;

    logic [3:0]            dec_bcd;
    logic                  dec_legal;
    logic                  dec_blank;
    seg7_dec_t             dec_c;

    // Input sample stage plus one-cycle-older copy for the stability compare
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_an  <= '1;
            s_seg <= '1;
            p_an  <= '1;
            p_seg <= '1;
        end else begin
            s_an  <= an_n;
            s_seg <= seg_n;
            p_an  <= s_an;
            p_seg <= s_seg;
        end
    end

`ifdef SEG7_CAP_DP_EN
    logic s_dp;
    logic p_dp;

    // Decimal point follows the same sample/compare pipeline as the segments
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_dp <= 1'b1;
            p_dp <= 1'b1;
        end else begin
            s_dp <= dp_n;
            p_dp <= s_dp;
        end
    end

    assign changed_c = (s_an != p_an) || (s_seg != p_seg) || (s_dp != p_dp);
`else
    assign changed_c = (s_an != p_an) || (s_seg != p_seg);
`endif

    // Exactly one enable low: non-zero active mask with a single set bit
    assign an_act_c    = ~s_an;
    assign an_onehot_c = (an_act_c != '0) &&
                         ((an_act_c & (an_act_c - NUM_DIGITS'(1))) == '0);

    // Settle counter: restarts on any sample change, saturates once stable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (changed_c) begin
            cnt <= '0;
        end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and capture strobe; a change seen during CAPTURE starts a
    // fresh settle so the new pattern is not lost behind the capture cycle
    always_comb begin
        state_nxt = state;
        capture_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (changed_c && an_onehot_c) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!an_onehot_c) begin
                    state_nxt = ST_IDLE;
                end else if (!changed_c && (cnt == CNT_LAST)) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                capture_c = 1'b1;
                if (changed_c) begin
                    state_nxt = an_onehot_c ? ST_SETTLE : ST_IDLE;
                end else begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (changed_c) begin
                    state_nxt = an_onehot_c ? ST_SETTLE : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Decode the older copy: it still holds the stable value during CAPTURE
    seg7_pattern_decode u_decode (
        .seg_n (p_seg),
        .bcd   (dec_bcd),
        .legal (dec_legal),
        .blank (dec_blank)
    );

    assign dec_c = '{bcd: dec_bcd, legal: dec_legal, blank: dec_blank};

    // Write the selected digit slot on capture; error pulse only for non-blank junk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_out     <= {NUM_DIGITS{BCD_BLANK}};
            digit_valid <= '0;
            pattern_err <= 1'b0;
        end else begin
            pattern_err <= capture_c && !dec_c.legal && !dec_c.blank;
            if (capture_c) begin
                for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                    if (!p_an[k]) begin
                        bcd_out[4*k +: 4] <= dec_c.bcd;
                        digit_valid[k]    <= dec_c.legal;
                    end
                end
            end
        end
    end

`ifdef SEG7_CAP_DP_EN
    // Decimal point of the captured digit, active-high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_out <= '0;
        end else if (capture_c) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (!p_an[k]) begin
                    dp_out[k] <= ~p_dp;
                end
            end
        end
    end
`endif

    // Whole frame is good only when every digit decoded to 0-9
    assign frame_valid = &digit_valid;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture (NUM_DIGITS=2, STABLE_CYCLES=4).
// A run-length reference model checks every cycle; a vector table and a few
// hand sequences check fixed expectations for the documented corner cases.
`timescale 1ns/1ps
module tb_seg7_scan_capture;

    localparam int SCI = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_n;
    logic [1:0] an_n;
    logic [7:0] bcd_out;
    logic [1:0] digit_valid;
    logic       frame_valid;
    logic       pattern_err;
    logic       dp_bit;
`ifdef SEG7_CAP_DP_EN
    logic       dp_n;
    logic [1:0] dp_out;
    assign dp_bit = dp_n;
`else
    assign dp_bit = 1'b1;
`endif

    int checks   = 0;
    int failures = 0;

    seg7_scan_capture #(
        .NUM_DIGITS    (2),
        .STABLE_CYCLES (4),
        .CNT_W         (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .an_n        (an_n),
`ifdef SEG7_CAP_DP_EN
        .dp_n        (dp_n),
        .dp_out      (dp_out),
`endif
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b000_0001;
            1: return 7'b100_1111;
            2: return 7'b001_0010;
            3: return 7'b000_0110;
            4: return 7'b100_1100;
            5: return 7'b010_0100;
            6: return 7'b010_0000;
            7: return 7'b000_1111;
            8: return 7'b000_0000;
            9: return 7'b000_0100;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run of identical samples with one enable low that
    // spans STABLE_CYCLES+1 edges is written two edges after its last needed sample
    logic [7:0] m_bcd   = 8'hFF;
    logic [1:0] m_valid = 2'b00;
    logic       m_err   = 1'b0;
    logic [1:0] m_dp    = 2'b00;
    logic [9:0] m_cur   = '1;
    int         m_run   = 1;
    bit         m_pv    = 1'b0;
    int         m_pedge = 0;
    logic [9:0] m_psmp  = '1;
    int         cyc     = 0;

    task automatic m_apply(input logic [9:0] smp);
        logic [1:0] an;
        logic [6:0] seg;
        int k;
        int v;
        an  = smp[8:7];
        seg = smp[6:0];
        k   = 0;
        v   = -1;
        for (int i = 0; i < 2; i++) if (!an[i]) k = i;
        for (int d = 0; d < 10; d++) if (seg_of(d) == seg) v = d;
        if (v >= 0) begin
            m_bcd[4*k +: 4] = 4'(v);
            m_valid[k]      = 1'b1;
        end else begin
            m_bcd[4*k +: 4] = 4'hF;
            m_valid[k]      = 1'b0;
            m_err           = (seg != 7'h7F);
        end
        m_dp[k] = ~smp[9];
    endtask

    always @(posedge clk) begin
        logic [9:0] smp;
        cyc++;
        smp   = {dp_bit, an_n, seg_n};
        m_err = 1'b0;
        if (!rst_n) begin
            m_bcd   = 8'hFF;
            m_valid = 2'b00;
            m_dp    = 2'b00;
            m_cur   = '1;
            m_run   = 1;
            m_pv    = 1'b0;
        end else begin
            if (m_pv && (m_pedge == cyc)) begin
                m_apply(m_psmp);
                m_pv = 1'b0;
            end
            if (smp != m_cur) begin
                m_cur = smp;
                m_run = 1;
            end else if (m_run < 1000) begin
                m_run++;
            end
            if ((m_run == SCI + 1) && ($countones(~smp[8:7]) == 1)) begin
                m_pv    = 1'b1;
                m_pedge = cyc + 2;
                m_psmp  = smp;
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_bcd_out", 32'(bcd_out), 32'(m_bcd));
            check("model_digit_valid", 32'(digit_valid), 32'(m_valid));
            check("model_frame_valid", 32'(frame_valid), 32'(&m_valid));
            check("model_pattern_err", 32'(pattern_err), 32'(m_err));
`ifdef SEG7_CAP_DP_EN
            check("model_dp_out", 32'(dp_out), 32'(m_dp));
`endif
        end
    end

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        int         hold;
        logic [7:0] bcd;
        logic [1:0] valid;
        logic       frame;
    } vec_t;

    vec_t vecs[10];
    int   pulses;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (pattern_err) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'b01, 7'h04, 8, 8'h93, 2'b11, 1'b1};
        vecs[1] = '{2'b10, 7'h24, 8, 8'h95, 2'b11, 1'b1};
        vecs[2] = '{2'b01, 7'h70, 8, 8'hF5, 2'b01, 1'b0};
        vecs[3] = '{2'b01, 7'h04, 8, 8'h95, 2'b11, 1'b1};
        vecs[4] = '{2'b01, 7'h7F, 8, 8'hF5, 2'b01, 1'b0};
        vecs[5] = '{2'b00, 7'h00, 10, 8'hF5, 2'b01, 1'b0};
        vecs[6] = '{2'b11, 7'h00, 10, 8'hF5, 2'b01, 1'b0};
        vecs[7] = '{2'b10, 7'h00, 8, 8'hF8, 2'b01, 1'b0};
        vecs[8] = '{2'b01, 7'h01, 8, 8'h08, 2'b11, 1'b1};
        vecs[9] = '{2'b10, 7'h4F, 8, 8'h01, 2'b11, 1'b1};

        rst_n = 1'b0;
        an_n  = 2'b11;
        seg_n = 7'h7F;
`ifdef SEG7_CAP_DP_EN
        dp_n  = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_bcd", 32'(bcd_out), 32'h0000_00FF);
        check("reset_valid", 32'(digit_valid), 32'h0);
        check("reset_frame", 32'(frame_valid), 32'h0);
        check("reset_err", 32'(pattern_err), 32'h0);

        // Capture latency: pins from edge t, result at edge t+6 and not before
        rst_n = 1'b1;
        an_n  = 2'b10;
        seg_n = 7'b000_0110;
        for (int i = 0; i <= 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("latency_valid", 32'(digit_valid), (i == 6) ? 32'h1 : 32'h0);
        end
        check("latency_bcd", 32'(bcd_out[3:0]), 32'h3);
        check("latency_frame", 32'(frame_valid), 32'h0);

        // Table of held patterns with cumulative expected outputs
        for (int v = 0; v < 10; v++) begin
            an_n  = vecs[v].an;
            seg_n = vecs[v].seg;
            repeat (vecs[v].hold) @(posedge clk);
            @(negedge clk);
            check("vec_bcd", 32'(bcd_out), 32'(vecs[v].bcd));
            check("vec_valid", 32'(digit_valid), 32'(vecs[v].valid));
            check("vec_frame", 32'(frame_valid), 32'(vecs[v].frame));
        end

        // Illegal pattern: exactly one error pulse; blank afterwards: none
        pulses = 0;
        an_n   = 2'b01;
        seg_n  = 7'b111_0000;
        step(10);
        check("illegal_pulse_count", 32'(pulses), 32'h1);
        check("illegal_bcd_hi", 32'(bcd_out[7:4]), 32'hF);
        check("illegal_valid_hi", 32'(digit_valid[1]), 32'h0);
        pulses = 0;
        seg_n  = 7'h7F;
        step(10);
        check("blank_pulse_count", 32'(pulses), 32'h0);
        check("blank_bcd", 32'(bcd_out), 32'h0000_00F1);

        // Glitching segments shorter than the settle window, then no/all enables
        pulses = 0;
        an_n   = 2'b10;
        for (int g = 0; g < 6; g++) begin
            seg_n = (g % 2 == 0) ? 7'b000_0110 : 7'b010_0100;
            step(3);
        end
        an_n = 2'b11;
        step(4);
        check("glitch_bcd", 32'(bcd_out), 32'h0000_00F1);
        check("glitch_valid", 32'(digit_valid), 32'h1);
        an_n  = 2'b00;
        seg_n = 7'b000_0000;
        step(10);
        check("no_enable_bcd", 32'(bcd_out), 32'h0000_00F1);
        check("no_enable_pulses", 32'(pulses), 32'h0);

        // Reset on the third settle edge aborts, then full latency from release
        an_n  = 2'b10;
        seg_n = 7'b000_0110;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_bcd", 32'(bcd_out), 32'h0000_00FF);
        check("midreset_valid", 32'(digit_valid), 32'h0);
        check("midreset_frame", 32'(frame_valid), 32'h0);
        rst_n = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(posedge clk);
            @(negedge clk);
            check("release_valid", 32'(digit_valid), (j == 7) ? 32'h1 : 32'h0);
        end
        check("release_bcd", 32'(bcd_out), 32'h0000_00F3);

`ifdef SEG7_CAP_DP_EN
        // Decimal point is captured with the digit and is part of stability
        an_n  = 2'b10;
        seg_n = 7'b000_1111;
        dp_n  = 1'b0;
        step(8);
        check("dp_on", 32'(dp_out), 32'h1);
        check("dp_bcd", 32'(bcd_out[3:0]), 32'h7);
        dp_n = 1'b1;
        step(8);
        check("dp_off", 32'(dp_out), 32'h0);
`endif

        // Randomized traffic against the model, with occasional resets
        for (int n = 0; n < 250; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 10) an_n = (r < 5) ? 2'b00 : 2'b11;
            else        an_n = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
            r = int'($urandom_range(0, 9));
            if (r < 8)       seg_n = seg_of(int'($urandom_range(0, 9)));
            else if (r == 8) seg_n = 7'h7F;
            else             seg_n = 7'($urandom);
`ifdef SEG7_CAP_DP_EN
            dp_n = 1'($urandom);
`endif
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            repeat (int'($urandom_range(1, 9))) begin
                @(posedge clk);
                @(negedge clk);
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
